// File: rtl/axi_bridge_pkg.sv
// Shared encodings for the AXI3 bridge arbiter: FSM states, AXI ids and size codes.
package axi_bridge_pkg;

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  // CPU size codes map onto AXI size by dropping the unused top bit.
  function automatic logic [2:0] axi_size(input logic [2:0] cpu_size);
    return {1'b0, cpu_size[1:0]};
  endfunction

endpackage

// File: rtl/axi_bridge_arbiter_wr.sv
// Write path of the bridge: a single-beat AW/W/B transaction per data write.
module axi_wr_channel
  import axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_req,
  input  logic        data_busy,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        wr_accept,
  output logic        b_done,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid
);

  w_state_t state;
  logic     aw_pending;
  logic     w_pending;

  assign wr_accept  = (state == W_IDLE) && wr_req && !data_busy;
  assign b_done     = (state == W_RESP) && bvalid;
  assign aw_pending = awvalid && !awready;
  assign w_pending  = wvalid && !wready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= W_IDLE;
      awaddr  <= '0;
      awsize  <= '0;
      awvalid <= 1'b0;
      wdata   <= '0;
      wstrb   <= '0;
      wvalid  <= 1'b0;
    end else begin
      unique case (state)
        W_IDLE: if (wr_accept) begin
          awaddr  <= data_addr;
          awsize  <= axi_size(data_size);
          wdata   <= data_wdata;
          wstrb   <= data_wstrb;
          awvalid <= 1'b1;
          wvalid  <= 1'b1;
          state   <= W_SEND;
        end
        // AW and W retire independently; both may complete in the same cycle.
        W_SEND: begin
          awvalid <= aw_pending;
          wvalid  <= w_pending;
          if (!aw_pending && !w_pending) state <= W_RESP;
        end
        W_RESP: if (bvalid) state <= W_IDLE;
        default: state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi_bridge_arbiter.sv
// Shares one AXI3 master between instruction line refills and single-beat data accesses.
module axi_bridge_arbiter
  import axi_bridge_pkg::*;
#(
  parameter int unsigned ILINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_rdy,
  output logic        ret_valid,
  output logic        ret_last,
  output logic [31:0] ret_data,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  ar_state_t ar_state;
  logic      inst_busy;
  logic      data_busy;
  logic      data_rd_grant;
  logic      wr_accept;
  logic      b_done;
  logic      data_ret;

  assign rready = 1'b1;
  assign bready = 1'b1;

  // Data reads win AR; an instruction grant still coexists with a data write accept.
  assign data_rd_grant = (ar_state == AR_IDLE) && data_req && !data_wr && !data_busy;
  assign rd_rdy        = (ar_state == AR_IDLE) && rd_req && !inst_busy && !data_rd_grant;
  assign data_addr_ok  = data_rd_grant || wr_accept;

  assign ret_valid    = rvalid && (rid == ID_INST);
  assign ret_last     = rlast;
  assign ret_data     = rdata;
  assign data_ret     = rvalid && (rid == ID_DATA);
  assign data_rdata   = rdata;
  assign data_data_ok = data_ret || b_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state <= AR_IDLE;
      araddr   <= '0;
      arid     <= '0;
      arlen    <= '0;
      arsize   <= '0;
      arvalid  <= 1'b0;
    end else begin
      unique case (ar_state)
        AR_IDLE:
          if (data_rd_grant) begin
            araddr   <= data_addr;
            arid     <= ID_DATA;
            arlen    <= '0;
            arsize   <= axi_size(data_size);
            arvalid  <= 1'b1;
            ar_state <= AR_SEND;
          end else if (rd_rdy) begin
            araddr   <= rd_addr;
            arid     <= ID_INST;
            arlen    <= 8'(ILINE_WORDS - 1);
            arsize   <= SIZE_WORD;
            arvalid  <= 1'b1;
            ar_state <= AR_SEND;
          end
        AR_SEND:
          if (arready) begin
            arvalid  <= 1'b0;
            ar_state <= AR_IDLE;
          end
        default: ar_state <= AR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_busy <= 1'b0;
      data_busy <= 1'b0;
    end else begin
      if (rd_rdy) inst_busy <= 1'b1;
      else if (ret_valid && rlast) inst_busy <= 1'b0;
      if (data_addr_ok) data_busy <= 1'b1;
      else if (data_data_ok) data_busy <= 1'b0;
    end
  end

  axi_wr_channel u_wr (
    .clk        (clk),
    .reset      (reset),
    .wr_req     (data_req && data_wr),
    .data_busy  (data_busy),
    .data_addr  (data_addr),
    .data_size  (data_size),
    .data_wdata (data_wdata),
    .data_wstrb (data_wstrb),
    .wr_accept  (wr_accept),
    .b_done     (b_done),
    .awaddr     (awaddr),
    .awsize     (awsize),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wvalid     (wvalid),
    .wready     (wready),
    .bvalid     (bvalid)
  );

endmodule
